// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: ALU opcodes, ROB tag width, CDB packet.
// No logic, so there is no latency.
// No handshakes, so there is no backpressure.
package ooo_pkg;

  localparam int ROB_ADDR_WIDTH = 4;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [ROB_ADDR_WIDTH-1:0] tag;
    logic [31:0]               data;
  } cdb_pkt_t;

endpackage

// File: rtl/alu_cdb_unit_result_fifo.sv
// Synchronous FIFO of CDB packets with flush; the head is read combinationally.
// A push shows up at the head on the cycle after the push edge.
// The caller must not push while full unless it also pops; a pop on empty is ignored.
module result_fifo
  import ooo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  cdb_pkt_t             push_data,
  input  logic                 pop,
  output cdb_pkt_t             head,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_pkt_t             mem [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic                 do_push;
  logic                 do_pop;

  // A full queue can still accept a push in the same cycle as a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_WIDTH'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write. Entries need no reset because count guards every read.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cdb_unit.sv
// Single-ALU execution unit: it registers an issued op, computes in EX, and queues the result for the CDB.
// A result issued in cycle N reaches the CDB in cycle N+2 when the queue is empty.
// issue_ready is credit-based (queue count + EX) and is independent of cdb_grant and issue_valid.
module alu_cdb_unit
  import ooo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic [3:0]                issue_alu_op,
  input  logic [31:0]               issue_src1_value,
  input  logic [31:0]               issue_src2_value,
  input  logic [ROB_ADDR_WIDTH-1:0] issue_dest_tag,
  output logic                      issue_ready,
  output logic                      cdb_valid,
  output logic [ROB_ADDR_WIDTH-1:0] cdb_tag,
  output logic [31:0]               cdb_data,
  input  logic                      cdb_grant,
  output logic [CNT_WIDTH-1:0]      result_count
);

  logic                      ex_valid;
  logic [3:0]                ex_op;
  logic [31:0]               ex_a;
  logic [31:0]               ex_b;
  logic [ROB_ADDR_WIDTH-1:0] ex_tag;
  logic [31:0]               ex_result;
  logic                      accept;
  logic [CNT_WIDTH:0]        occupancy;
  cdb_pkt_t                  head;
  cdb_pkt_t                  last_pkt;

  function automatic logic [31:0] alu_compute(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << sh;
      ALU_SLT:    return {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU:   return {31'b0, (a < b)};
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    return $unsigned($signed(a) >>> sh);
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_PASS_B: return b;
      default:    return 32'd0;
    endcase
  endfunction

  // A credit is the sum of queued results and the op in EX, so every accepted op has a slot.
  assign occupancy   = {1'b0, result_count} + {{CNT_WIDTH{1'b0}}, ex_valid};
  assign issue_ready = occupancy < (CNT_WIDTH + 1)'(FIFO_DEPTH);
  assign accept      = issue_valid && issue_ready && !flush;
  assign ex_result   = alu_compute(ex_op, ex_a, ex_b);

  // EX register captures the accepted op; a flush or reset squashes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_tag   <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_op  <= issue_alu_op;
        ex_a   <= issue_src1_value;
        ex_b   <= issue_src2_value;
        ex_tag <= issue_dest_tag;
      end
    end
  end

  result_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_result_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (ex_valid),
    .push_data ('{tag: ex_tag, data: ex_result}),
    .pop       (cdb_valid && cdb_grant),
    .head      (head),
    .count     (result_count)
  );

  // Remember the last presented packet so the CDB fields hold steady while the queue is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_pkt <= '0;
    end else if (cdb_valid) begin
      last_pkt <= head;
    end
  end

  assign cdb_valid = (result_count != '0);
  assign cdb_tag   = cdb_valid ? head.tag  : last_pkt.tag;
  assign cdb_data  = cdb_valid ? head.data : last_pkt.data;

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Self-checking bench for alu_cdb_unit with a queue-based reference model.
// The model timestamps each accepted op and treats it as visible on the CDB two cycles later.
// The bench drives issue_valid only when the model says a credit is free.
module tb_alu_cdb_unit;
  import ooo_pkg::*;

  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic                      clock = 1'b0;
  logic                      reset, flush, issue_valid, issue_ready, cdb_valid, cdb_grant;
  logic [3:0]                issue_alu_op;
  logic [31:0]               issue_src1_value, issue_src2_value, cdb_data;
  logic [ROB_ADDR_WIDTH-1:0] issue_dest_tag, cdb_tag;
  logic [CW-1:0]             result_count;

  alu_cdb_unit #(.FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_alu_op(issue_alu_op), .issue_src1_value(issue_src1_value),
    .issue_src2_value(issue_src2_value), .issue_dest_tag(issue_dest_tag),
    .issue_ready(issue_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_grant(cdb_grant), .result_count(result_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ROB_ADDR_WIDTH-1:0] tag;
    logic [31:0]               data;
    int                        cyc;
  } item_t;

  item_t                     mq[$];
  int                        cyc;
  logic [ROB_ADDR_WIDTH-1:0] last_tag;
  logic [31:0]               last_data;
  int                        n_checks;
  int                        n_fail;

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << s;
      3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> s;
      7:  return 32'(int'(a) >>> s);
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Model view of the current cycle.
  function automatic int m_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].cyc <= cyc - 2) n++;
    return n;
  endfunction
  function automatic bit m_ready();
    return mq.size() < D;
  endfunction
  function automatic bit m_valid();
    return m_count() != 0;
  endfunction
  function automatic logic [ROB_ADDR_WIDTH-1:0] m_tag();
    return m_valid() ? mq[0].tag : last_tag;
  endfunction
  function automatic logic [31:0] m_data();
    return m_valid() ? mq[0].data : last_data;
  endfunction

  task automatic drive(input bit want, input int op, input logic [31:0] a, input logic [31:0] b,
                       input int tag, input bit g, input bit f, input bit r);
    issue_valid      = want && m_ready();
    issue_alu_op     = 4'(op);
    issue_src1_value = a;
    issue_src2_value = b;
    issue_dest_tag   = ROB_ADDR_WIDTH'(tag);
    cdb_grant        = g;
    flush            = f;
    reset            = r;
  endtask

  // Apply the current inputs to the model, then move to just after the next rising edge.
  task automatic adv();
    bit    v;
    item_t it;
    v = m_valid();
    if (reset) begin
      mq.delete();
      last_tag  = '0;
      last_data = '0;
    end else begin
      if (v) begin
        last_tag  = mq[0].tag;
        last_data = mq[0].data;
      end
      if (flush) mq.delete();
      else begin
        if (v && cdb_grant) void'(mq.pop_front());
        if (issue_valid) begin
          it.tag  = issue_dest_tag;
          it.data = ref_alu(int'(issue_alu_op), issue_src1_value, issue_src2_value);
          it.cyc  = cyc;
          mq.push_back(it);
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit g);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, g, 0, 0);
      @(negedge clock);
      adv();
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1); @(negedge clock); adv();
    end
    for (int pass = 0; pass < 2; pass++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      n_checks++;
      if (issue_ready !== 1'b1 || cdb_valid !== 1'b0 || result_count !== '0) begin
        n_fail++;
        $display("FAIL reset_ctrl pass=%0d got rdy=%b v=%b cnt=%0d want rdy=1 v=0 cnt=0",
                 pass, issue_ready, cdb_valid, result_count);
      end
      n_checks++;
      if (cdb_tag !== '0 || cdb_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_cdb pass=%0d got tag=%0d data=%h want 0/0", pass, cdb_tag, cdb_data);
      end
      adv();
      if (pass == 0) begin
        for (int k = 0; k < 6; k++) begin
          drive(1, 0, 32'(k), 32'd1, k + 5, 0, 0, 0); @(negedge clock); adv();
        end
        for (int k = 0; k < 3; k++) begin
          drive(1, 0, 32'd9, 32'd9, 2, 1, 0, 1); @(negedge clock); adv();
        end
      end
    end
  endtask

  task automatic test_latency();
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 0, 32'd5, 32'd7, 3, 1, 0, 0);
      @(negedge clock);
      n_checks++;
      if (cdb_valid !== (k == 2)) begin
        n_fail++;
        $display("FAIL latency_valid k=%0d got %b want %b", k, cdb_valid, (k == 2));
      end
      if (k == 2) begin
        n_checks++;
        if (cdb_tag !== 4'd3 || cdb_data !== 32'd12) begin
          n_fail++;
          $display("FAIL latency_pkt got tag=%0d data=%0d want tag=3 data=12", cdb_tag, cdb_data);
        end
      end
      adv();
    end
  endtask

  task automatic test_op_table();
    int          ops [11] = '{1, 3, 4, 7, 2, 10, 15, 6, 9, 8, 11};
    logic [31:0] av  [11] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h0,
                              32'h5, 32'h80000000, 32'hF0F0, 32'hF0F0, 32'h1};
    logic [31:0] bv  [11] = '{32'h1, 32'h1, 32'h1, 32'h4, 32'd33, 32'hABCDE000,
                              32'h6, 32'h4, 32'hFF00, 32'h0F0F, 32'h1};
    logic [31:0] ev  [11] = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'hF8000000, 32'h2, 32'hABCDE000,
                              32'h0, 32'h08000000, 32'hF000, 32'hFFFF, 32'h0};
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 3; k++) begin
        drive(k == 0, ops[i], av[i], bv[i], i, 1, 0, 0);
        @(negedge clock);
        if (k == 2) begin
          n_checks++;
          if (cdb_valid !== 1'b1 || cdb_tag !== 4'(i) || cdb_data !== ev[i]) begin
            n_fail++;
            $display("FAIL op_table op=%0d got v=%b tag=%0d data=%h want v=1 tag=%0d data=%h",
                     ops[i], cdb_valid, cdb_tag, cdb_data, i, ev[i]);
          end
        end
        adv();
      end
    end
    for (int k = 0; k < 40; k++) begin
      drive(1, $urandom_range(0, 15), $urandom, $urandom, $urandom_range(0, 15), 1, 0, 0);
      @(negedge clock);
      n_checks++;
      if (cdb_valid !== m_valid() || cdb_tag !== m_tag() || cdb_data !== m_data()) begin
        n_fail++;
        $display("FAIL op_random k=%0d got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h",
                 k, cdb_valid, cdb_tag, cdb_data, m_valid(), m_tag(), m_data());
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    int next_tag = 0;
    int seen[$];
    for (int k = 0; k < 8; k++) begin
      drive(next_tag < 6, 0, 32'(next_tag), 32'd0, next_tag, 0, 0, 0);
      @(negedge clock);
      n_checks++;
      if (issue_ready !== (k < 4) || result_count !== CW'((k < 1) ? 0 : ((k - 1 > 4) ? 4 : k - 1))) begin
        n_fail++;
        $display("FAIL bp_fill k=%0d got rdy=%b cnt=%0d", k, issue_ready, result_count);
      end
      if (issue_valid) next_tag++;
      adv();
    end
    n_checks++;
    if (next_tag !== 4) begin
      n_fail++;
      $display("FAIL bp_accepted got %0d want 4", next_tag);
    end
    for (int k = 0; k < 20; k++) begin
      drive(next_tag < 6, 0, 32'(next_tag), 32'd0, next_tag, 1, 0, 0);
      @(negedge clock);
      if (cdb_valid) seen.push_back(int'(cdb_tag));
      if (issue_valid) next_tag++;
      adv();
    end
    n_checks++;
    if (seen.size() != 6) begin
      n_fail++;
      $display("FAIL bp_drain_count got %0d results want 6", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      n_checks++;
      if (seen[i] != i) begin
        n_fail++;
        $display("FAIL bp_order idx=%0d got tag %0d want %0d", i, seen[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 8, $urandom, $urandom, k, 0, 0, 0); @(negedge clock); adv();
    end
    for (int k = 0; k < 40; k++) begin
      drive(1, $urandom_range(0, 10), $urandom, $urandom, $urandom_range(0, 15), 1, 0, 0);
      @(negedge clock);
      if (cdb_valid) pops++;
      n_checks++;
      if (cdb_valid !== m_valid() || cdb_tag !== m_tag() || cdb_data !== m_data()
          || issue_ready !== m_ready() || result_count !== CW'(m_count())) begin
        n_fail++;
        $display("FAIL b2b_model k=%0d got v=%b tag=%0d data=%h rdy=%b cnt=%0d want v=%b tag=%0d data=%h rdy=%b cnt=%0d",
                 k, cdb_valid, cdb_tag, cdb_data, issue_ready, result_count,
                 m_valid(), m_tag(), m_data(), m_ready(), m_count());
      end
      if (k >= 3) begin
        n_checks++;
        if (result_count !== CW'(2)) begin
          n_fail++;
          $display("FAIL b2b_steady_count k=%0d got %0d want 2", k, result_count);
        end
      end
      adv();
    end
    n_checks++;
    if (pops != 40) begin
      n_fail++;
      $display("FAIL b2b_throughput got %0d results in 40 cycles want 40", pops);
    end
  endtask

  task automatic test_flush();
    idle(8, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'd100, 32'(k), 7 + k, 0, 0, 0); @(negedge clock); adv();
    end
    drive(1, 0, 32'd1, 32'd1, 10, 1, 1, 0);
    @(negedge clock);
    n_checks++;
    if (result_count !== CW'(2) || cdb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup got cnt=%0d v=%b want cnt=2 v=1", result_count, cdb_valid);
    end
    adv();
    for (int k = 0; k < 7; k++) begin
      drive(k == 2, 0, 32'd1, 32'd2, 11, 1, 0, 0);
      @(negedge clock);
      if (k == 0) begin
        n_checks++;
        if (cdb_valid !== 1'b0 || result_count !== '0 || issue_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_clear got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1",
                   cdb_valid, result_count, issue_ready);
        end
      end
      n_checks++;
      if (cdb_valid !== (k == 4) || (cdb_valid && (cdb_tag !== 4'd11 || cdb_data !== 32'd3))) begin
        n_fail++;
        $display("FAIL flush_after k=%0d got v=%b tag=%0d data=%0d want v=%b tag=11 data=3",
                 k, cdb_valid, cdb_tag, cdb_data, (k == 4));
      end
      adv();
    end
  endtask

  task automatic test_random_traffic();
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom, $urandom_range(0, 40),
            $urandom_range(0, 15), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 1);
      @(negedge clock);
      n_checks++;
      if (cdb_valid !== m_valid() || cdb_tag !== m_tag() || cdb_data !== m_data()
          || issue_ready !== m_ready() || result_count !== CW'(m_count())) begin
        n_fail++;
        $display("FAIL random k=%0d got v=%b tag=%0d data=%h rdy=%b cnt=%0d want v=%b tag=%0d data=%h rdy=%b cnt=%0d",
                 k, cdb_valid, cdb_tag, cdb_data, issue_ready, result_count,
                 m_valid(), m_tag(), m_data(), m_ready(), m_count());
      end
      adv();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    last_tag = '0;
    last_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clock);
    #1;
    test_reset();
    test_latency();
    test_op_table();
    idle(8, 1);
    test_backpressure();
    idle(8, 1);
    test_back_to_back();
    test_flush();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
